cordic_pipe: RTL

Fully pipelined, parametrised CORDIC engine that succeeds the fixed 16-bit sin/cos unit. It accepts one sample per clock and supports two modes: rotation (sin/cos or vector rotation by an angle) and vectoring (magnitude and atan2). It carries a valid flag and a mode tag down the pipe, with a clock-enable stall. It sits between the phase/sample sources and the DSP datapath, and is the shared trig/polar engine for all channels.

---
 rtl/cordic_pkg.sv | 71 +++++++
 rtl/cordic_stage.sv | 75 +++++++
 rtl/cordic_pipe.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/cordic_pkg.sv
// Shared definitions for the pipelined CORDIC engine: mode encoding,
// Q-format constants for the default 16-bit build and the arctangent table.
package cordic_pkg;

    typedef enum logic {
        MODE_ROT = 1'b0,
        MODE_VEC = 1'b1
    } cordic_mode_e;

    // Constants for the default 16-bit build (Q2.14 data, 2^16 per turn).
    localparam int CORDIC_W_DEF   = 16;
    localparam int Q_ONE          = 1 << (CORDIC_W_DEF - 2);
    localparam int ANG_90         = 1 << (CORDIC_W_DEF - 2);
    localparam int INV_K_PRESCALE = 9949;

    // Extra integer bits above Q2 so the gain (~1.65) times the sqrt(2)
    // corner magnitude never wraps before the output clamp.
    localparam int HEADROOM = 2;

    // Internal x/y width: data width, fractional guard bits, gain headroom.
    function automatic int cordic_xw(input int w, input int g);
        return w + g + HEADROOM;
    endfunction

    // round(atan(2^-i) * 2^w / 2pi). The table holds the angles at 2^32
    // per turn; narrower widths are rounded down from it.
    function automatic logic [31:0] atan_lut(input int i, input int w);
        logic [31:0] t;
        logic [32:0] r;
        case (i)
            0:  t = 32'h2000_0000;
            1:  t = 32'h12E4_051E;
            2:  t = 32'h09FB_385B;
            3:  t = 32'h0511_11D4;
            4:  t = 32'h028B_0D43;
            5:  t = 32'h0145_D7E1;
            6:  t = 32'h00A2_F61E;
            7:  t = 32'h0051_7C55;
            8:  t = 32'h0028_BE53;
            9:  t = 32'h0014_5F2F;
            10: t = 32'h000A_2F98;
            11: t = 32'h0005_17CC;
            12: t = 32'h0002_8BE6;
            13: t = 32'h0001_45F3;
            14: t = 32'h0000_A2FA;
            15: t = 32'h0000_517D;
            16: t = 32'h0000_28BE;
            17: t = 32'h0000_145F;
            18: t = 32'h0000_0A30;
            19: t = 32'h0000_0518;
            20: t = 32'h0000_028C;
            21: t = 32'h0000_0146;
            22: t = 32'h0000_00A3;
            23: t = 32'h0000_0051;
            24: t = 32'h0000_0029;
            25: t = 32'h0000_0014;
            26: t = 32'h0000_000A;
            27: t = 32'h0000_0005;
            28: t = 32'h0000_0003;
            29: t = 32'h0000_0001;
            30: t = 32'h0000_0001;
            default: t = 32'h0000_0000;
        endcase
        if (w >= 32) begin
            return t;
        end
        r = {1'b0, t} + (33'd1 << (31 - w));
        return 32'(r >> (32 - w));
    endfunction

endpackage

// File: rtl/cordic_stage.sv
// One registered CORDIC micro-rotation. Valid and mode ride along with the
// data so that rotation and vectoring samples can interleave freely.
module cordic_stage
    import cordic_pkg::*;
#(
    parameter int W     = 16,
    parameter int G     = 2,
    parameter int SHIFT = 0,
    localparam int XW   = cordic_xw(W, G)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ce,
    input  logic                 i_valid,
    input  logic                 i_mode,
    input  logic signed [XW-1:0] i_x,
    input  logic signed [XW-1:0] i_y,
    input  logic signed [W-1:0]  i_z,
    output logic                 o_valid,
    output logic                 o_mode,
    output logic signed [XW-1:0] o_x,
    output logic signed [XW-1:0] o_y,
    output logic signed [W-1:0]  o_z
);

    localparam logic [31:0]        ANG_FULL = atan_lut(SHIFT, W);
    localparam logic signed [W-1:0] ANGLE   = ANG_FULL[W-1:0];

    logic                 r_valid;
    logic                 r_mode;
    logic signed [XW-1:0] r_x;
    logic signed [XW-1:0] r_y;
    logic signed [W-1:0]  r_z;

    logic signed [XW-1:0] w_x_sh;
    logic signed [XW-1:0] w_y_sh;
    logic                 w_d_pos;

    assign w_x_sh = i_x >>> SHIFT;
    assign w_y_sh = i_y >>> SHIFT;

    // d = +1 when the residual angle is non-negative (rotation) or when y is
    // negative (vectoring drives y toward zero); zero counts as positive.
    assign w_d_pos = (i_mode == MODE_VEC) ? i_y[XW-1] : ~i_z[W-1];

    // Micro-rotation by +/-atan(2^-SHIFT), held while ce is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_mode  <= 1'b0;
            r_x     <= '0;
            r_y     <= '0;
            r_z     <= '0;
        end else if (ce) begin
            r_valid <= i_valid;
            r_mode  <= i_mode;
            if (w_d_pos) begin
                r_x <= i_x - w_y_sh;
                r_y <= i_y + w_x_sh;
                r_z <= i_z - ANGLE;
            end else begin
                r_x <= i_x + w_y_sh;
                r_y <= i_y - w_x_sh;
                r_z <= i_z + ANGLE;
            end
        end
    end

    assign o_valid = r_valid;
    assign o_mode  = r_mode;
    assign o_x     = r_x;
    assign o_y     = r_y;
    assign o_z     = r_z;

endmodule

// File: rtl/cordic_pipe.sv
// Fully pipelined CORDIC engine: quadrant pre-rotation, ITER micro-rotation
// stages and a saturating output stage. One sample per enabled clock, no
// gain compensation, latency ITER+2 enabled cycles.
module cordic_pipe
    import cordic_pkg::*;
#(
    parameter int W    = 16,
    parameter int ITER = 14,
    parameter int G    = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ce,
    input  logic                in_valid,
    input  logic                in_mode,
    input  logic signed [W-1:0] in_x,
    input  logic signed [W-1:0] in_y,
    input  logic signed [W-1:0] in_z,
    output logic                out_valid,
    output logic                out_mode,
    output logic signed [W-1:0] out_x,
    output logic signed [W-1:0] out_y,
    output logic signed [W-1:0] out_z
);

    localparam int XW = cordic_xw(W, G);

    localparam logic signed [W-1:0]  ANG_RIGHT = {2'b01, {(W-2){1'b0}}};
    localparam logic signed [XW-1:0] SAT_HI    = {{(XW-W+1){1'b0}}, {(W-1){1'b1}}};
    localparam logic signed [XW-1:0] SAT_LO    = {{(XW-W+1){1'b1}}, {(W-1){1'b0}}};

    // Clamp an internal-width value to the W-bit output range.
    function automatic logic signed [W-1:0] sat_w(input logic signed [XW-1:0] v);
        logic signed [W-1:0] res;
        if (v > SAT_HI) begin
            res = SAT_HI[W-1:0];
        end else if (v < SAT_LO) begin
            res = SAT_LO[W-1:0];
        end else begin
            res = v[W-1:0];
        end
        return res;
    endfunction

    // Input widened to the internal format: sign-extended, guard bits below.
    logic signed [XW-1:0] w_x_ext;
    logic signed [XW-1:0] w_y_ext;
    logic signed [XW-1:0] w_x_pre;
    logic signed [XW-1:0] w_y_pre;
    logic signed [W-1:0]  w_z_pre;

    assign w_x_ext = XW'(in_x) <<< G;
    assign w_y_ext = XW'(in_y) <<< G;

    // Quadrant pre-rotation so the micro-rotations only have to cover +/-90.
    always_comb begin
        w_x_pre = w_x_ext;
        w_y_pre = w_y_ext;
        w_z_pre = in_z;
        if (in_mode == MODE_ROT) begin
            if (in_z > ANG_RIGHT) begin
                w_x_pre = -w_y_ext;
                w_y_pre = w_x_ext;
                w_z_pre = in_z - ANG_RIGHT;
            end else if (in_z < -ANG_RIGHT) begin
                w_x_pre = w_y_ext;
                w_y_pre = -w_x_ext;
                w_z_pre = in_z + ANG_RIGHT;
            end
        end else begin
            w_z_pre = '0;
            if (in_x[W-1]) begin
                if (!in_y[W-1]) begin
                    w_x_pre = w_y_ext;
                    w_y_pre = -w_x_ext;
                    w_z_pre = ANG_RIGHT;
                end else begin
                    w_x_pre = -w_y_ext;
                    w_y_pre = w_x_ext;
                    w_z_pre = -ANG_RIGHT;
                end
            end
        end
    end

    logic                 r_vld_p0;
    logic                 r_mode_p0;
    logic signed [XW-1:0] r_x_p0;
    logic signed [XW-1:0] r_y_p0;
    logic signed [W-1:0]  r_z_p0;

    // Stage 0: register the pre-rotated sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld_p0  <= 1'b0;
            r_mode_p0 <= 1'b0;
            r_x_p0    <= '0;
            r_y_p0    <= '0;
            r_z_p0    <= '0;
        end else if (ce) begin
            r_vld_p0  <= in_valid;
            r_mode_p0 <= in_mode;
            r_x_p0    <= w_x_pre;
            r_y_p0    <= w_y_pre;
            r_z_p0    <= w_z_pre;
        end
    end

    logic                 w_vld  [0:ITER];
    logic                 w_mode [0:ITER];
    logic signed [XW-1:0] w_x    [0:ITER];
    logic signed [XW-1:0] w_y    [0:ITER];
    logic signed [W-1:0]  w_z    [0:ITER];

    assign w_vld[0]  = r_vld_p0;
    assign w_mode[0] = r_mode_p0;
    assign w_x[0]    = r_x_p0;
    assign w_y[0]    = r_y_p0;
    assign w_z[0]    = r_z_p0;

    // Stages 1..ITER: stage i shifts by i-1.
    for (genvar i = 1; i <= ITER; i++) begin : g_stage
        cordic_stage #(
            .W     (W),
            .G     (G),
            .SHIFT (i - 1)
        ) u_stage (
            .clk     (clk),
            .rst_n   (rst_n),
            .ce      (ce),
            .i_valid (w_vld[i-1]),
            .i_mode  (w_mode[i-1]),
            .i_x     (w_x[i-1]),
            .i_y     (w_y[i-1]),
            .i_z     (w_z[i-1]),
            .o_valid (w_vld[i]),
            .o_mode  (w_mode[i]),
            .o_x     (w_x[i]),
            .o_y     (w_y[i]),
            .o_z     (w_z[i])
        );
    end

    logic signed [XW-1:0] w_x_fin;
    logic signed [XW-1:0] w_y_fin;

    assign w_x_fin = w_x[ITER] >>> G;
    assign w_y_fin = w_y[ITER] >>> G;

    logic                r_out_valid;
    logic                r_out_mode;
    logic signed [W-1:0] r_out_x;
    logic signed [W-1:0] r_out_y;
    logic signed [W-1:0] r_out_z;

    // Output stage: drop guard bits, saturate x/y, pass the angle through.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_mode  <= 1'b0;
            r_out_x     <= '0;
            r_out_y     <= '0;
            r_out_z     <= '0;
        end else if (ce) begin
            r_out_valid <= w_vld[ITER];
            r_out_mode  <= w_mode[ITER];
            r_out_x     <= sat_w(w_x_fin);
            r_out_y     <= sat_w(w_y_fin);
            r_out_z     <= w_z[ITER];
        end
    end

    assign out_valid = r_out_valid;
    assign out_mode  = r_out_mode;
    assign out_x     = r_out_x;
    assign out_y     = r_out_y;
    assign out_z     = r_out_z;

endmodule
